// File: rtl/guess_grader.sv
// Grades a 12-bit guess against the loaded master pattern over 10 cycles:
// 4 position cycles (Znarly), then 6 shape cycles (Znarly + Zood total).
module guess_grader #(
  parameter int MAX_ROUNDS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        startGame,
  input  logic [11:0] masterPattern,
  input  logic        masterLoaded,
  input  logic [11:0] Guess,
  input  logic        gradeGuess,
  output logic        busy,
  output logic        graded,
  output logic        guessRejected,
  output logic [2:0]  Znarly,
  output logic [2:0]  Zood,
  output logic [3:0]  roundNumber,
  output logic        gameWon,
  output logic        gameOver,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE, EXACT, SHAPE, DONE} state_t;

  localparam logic [3:0] MAX_R = 4'(MAX_ROUNDS);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [2:0]  shape_q, shape_d;
  logic [11:0] g_q, g_d, m_q, m_d;
  logic [2:0]  exact_q, exact_d, sum_min_q, sum_min_d;
  logic [2:0]  znarly_q, znarly_d, zood_q, zood_d;
  logic [3:0]  round_q, round_d;
  logic        won_q, won_d, over_q, over_d, rej_q, rej_d;

  logic [2:0]  g_fld, m_fld, cnt_m, cnt_g, min_cnt, sum_next;
  logic        guess_ok;

  function automatic logic [2:0] count_eq(input logic [11:0] p, input logic [2:0] s);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (p[3*i +: 3] == s) n = n + 3'd1;
    end
    return n;
  endfunction

  function automatic logic code_ok(input logic [2:0] c);
    return (c != 3'b000) && (c != 3'b111);
  endfunction

  // Handshake: gradeGuess is a request sampled only while idle, loaded and
  // not game-over; it is never queued. busy covers the 10 grading cycles and
  // graded pulses once when results are valid. Hold gradeGuess for one cycle.
  always_comb begin
    g_fld = 3'd0;
    m_fld = 3'd0;
    case (idx_q)
      2'd0: begin g_fld = g_q[2:0];  m_fld = m_q[2:0];  end
      2'd1: begin g_fld = g_q[5:3];  m_fld = m_q[5:3];  end
      2'd2: begin g_fld = g_q[8:6];  m_fld = m_q[8:6];  end
      default: begin g_fld = g_q[11:9]; m_fld = m_q[11:9]; end
    endcase
    cnt_m    = count_eq(m_q, shape_q);
    cnt_g    = count_eq(g_q, shape_q);
    min_cnt  = (cnt_m < cnt_g) ? cnt_m : cnt_g;
    sum_next = sum_min_q + min_cnt;
    guess_ok = code_ok(Guess[2:0]) && code_ok(Guess[5:3]) &&
               code_ok(Guess[8:6]) && code_ok(Guess[11:9]);
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shape_d   = shape_q;
    g_d       = g_q;
    m_d       = m_q;
    exact_d   = exact_q;
    sum_min_d = sum_min_q;
    znarly_d  = znarly_q;
    zood_d    = zood_q;
    round_d   = round_q;
    won_d     = won_q;
    over_d    = over_q;
    rej_d     = 1'b0;

    if (startGame) begin
      state_d  = IDLE;
      znarly_d = 3'd0;
      zood_d   = 3'd0;
      round_d  = 4'd0;
      won_d    = 1'b0;
      over_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gradeGuess && masterLoaded && !over_q) begin
            if (!guess_ok) begin
              rej_d = 1'b1;
            end else begin
              g_d       = Guess;
              m_d       = masterPattern;
              exact_d   = 3'd0;
              sum_min_d = 3'd0;
              idx_d     = 2'd0;
              state_d   = EXACT;
            end
          end
        end
        EXACT: begin
          if (g_fld == m_fld) exact_d = exact_q + 3'd1;
          if (idx_q == 2'd3) begin
            state_d = SHAPE;
            shape_d = 3'd1;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
        SHAPE: begin
          sum_min_d = sum_next;
          if (shape_q == 3'd6) begin
            state_d  = DONE;
            znarly_d = exact_q;
            zood_d   = (sum_next >= exact_q) ? (sum_next - exact_q) : 3'd0;
            round_d  = round_q + 4'd1;
            // Win/over latch with the results so they are visible alongside graded.
            if (exact_q == 3'd4) won_d = 1'b1;
            if (exact_q == 3'd4 || (round_q + 4'd1) == MAX_R) over_d = 1'b1;
          end else begin
            shape_d = shape_q + 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      shape_q   <= 3'd0;
      g_q       <= 12'd0;
      m_q       <= 12'd0;
      exact_q   <= 3'd0;
      sum_min_q <= 3'd0;
      znarly_q  <= 3'd0;
      zood_q    <= 3'd0;
      round_q   <= 4'd0;
      won_q     <= 1'b0;
      over_q    <= 1'b0;
      rej_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shape_q   <= shape_d;
      g_q       <= g_d;
      m_q       <= m_d;
      exact_q   <= exact_d;
      sum_min_q <= sum_min_d;
      znarly_q  <= znarly_d;
      zood_q    <= zood_d;
      round_q   <= round_d;
      won_q     <= won_d;
      over_q    <= over_d;
      rej_q     <= rej_d;
    end
  end

  assign busy          = (state_q == EXACT) || (state_q == SHAPE);
  assign graded        = (state_q == DONE);
  assign guessRejected = rej_q;
  assign Znarly        = znarly_q;
  assign Zood          = zood_q;
  assign roundNumber   = round_q;
  assign gameWon       = won_q;
  assign gameOver      = over_q;
  assign dbg_state     = state_q;

endmodule
